edge_detect_mc: RTL and testbench

EDGE_DETECT_MC -- requirements
Module: edge_detect_mc

---
 rtl/edge_detect_mc.sv | 147 ++++++++++++++
 tb/tb_edge_detect_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_mc.sv
// edge_detect_mc
//   Multi-channel input conditioner. Each channel synchronises an
//   asynchronous level, debounces it against a shared length, and reports
//   filtered edges. Mode-selected events are latched into sticky flags,
//   with an overrun flag and a combined interrupt.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   data_in    [CH]      asynchronous level inputs
//   deb_len    [DEB_W]   debounce length in cycles (0 behaves as 1)
//   mode       [2*CH]    per-channel event select {fall, rise}
//   irq_en     [CH]      per-channel interrupt enable
//   clr        [CH]      write-1-to-clear for sticky and overrun
//   data_filt  [CH]      debounced level
//   pos_edge   [CH]      one-cycle pulse on filtered rising edge
//   neg_edge   [CH]      one-cycle pulse on filtered falling edge
//   evt        [CH]      edges gated by mode
//   sticky     [CH]      latched evt, held until clr
//   overrun    [CH]      evt seen while sticky already set
//   irq                  OR of sticky & irq_en

module edge_detect_mc #(
   parameter int CH          = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DEB_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH-1:0]     data_in,
   input  logic [DEB_W-1:0]  deb_len,
   input  logic [2*CH-1:0]   mode,
   input  logic [CH-1:0]     irq_en,
   input  logic [CH-1:0]     clr,
   output logic [CH-1:0]     data_filt,
   output logic [CH-1:0]     pos_edge,
   output logic [CH-1:0]     neg_edge,
   output logic [CH-1:0]     evt,
   output logic [CH-1:0]     sticky,
   output logic [CH-1:0]     overrun,
   output logic              irq
);

   // Synchroniser chains: bit 0 is the first stage, MSB the last.
   logic [SYNC_STAGES-1:0] sync_q [CH];
   logic [CH-1:0]          sync_lvl;

   logic [CH-1:0]          f_q;
   logic [CH-1:0]          f_nxt;
   logic [CH-1:0]          fd_q;
   logic [DEB_W-1:0]       cnt_q   [CH];
   logic [DEB_W-1:0]       cnt_nxt [CH];

   logic [CH-1:0]          sticky_q;
   logic [CH-1:0]          sticky_nxt;
   logic [CH-1:0]          ovr_q;
   logic [CH-1:0]          ovr_nxt;

   // One bit wider than the counter so cnt+1 never wraps in the compare.
   logic [DEB_W:0]         thresh;

   assign thresh = (deb_len == '0) ? (DEB_W+1)'(1) : {1'b0, deb_len};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < CH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], data_in[i]};
         end
      end
   end

   always_comb begin
      sync_lvl = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         sync_lvl[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   // Debounce: any cycle where the synchronised level agrees with the
   // filtered level restarts the count, so short excursions are dropped.
   always_comb begin
      f_nxt = f_q;
      for (int unsigned i = 0; i < CH; i++) begin
         cnt_nxt[i] = '0;
         if (sync_lvl[i] != f_q[i]) begin
            if (({1'b0, cnt_q[i]} + (DEB_W+1)'(1)) >= thresh) begin
               f_nxt[i] = sync_lvl[i];
            end else begin
               cnt_nxt[i] = cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q  <= '0;
         fd_q <= '0;
         for (int unsigned i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         f_q  <= f_nxt;
         fd_q <= f_q;
         for (int unsigned i = 0; i < CH; i++) begin
            cnt_q[i] <= cnt_nxt[i];
         end
      end
   end

   assign data_filt = f_q;
   assign pos_edge  = f_q & ~fd_q;
   assign neg_edge  = ~f_q & fd_q;

   always_comb begin
      evt = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         evt[i] = (pos_edge[i] & mode[2*i]) | (neg_edge[i] & mode[2*i+1]);
      end
   end

   // A new event wins over a coincident clear for sticky, while the clear
   // wins for overrun.
   always_comb begin
      sticky_nxt = (sticky_q & ~clr) | evt;
      ovr_nxt    = ~clr & (ovr_q | (evt & sticky_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= '0;
         ovr_q    <= '0;
      end else begin
         sticky_q <= sticky_nxt;
         ovr_q    <= ovr_nxt;
      end
   end

   assign sticky  = sticky_q;
   assign overrun = ovr_q;
   assign irq     = |(sticky_q & irq_en);

endmodule

// File: tb/tb_edge_detect_mc.sv
module tb_edge_detect_mc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] data_in;
   logic [7:0] deb_len;
   logic [7:0] mode;
   logic [3:0] irq_en;
   logic [3:0] clr;
   logic [3:0] data_filt, pos_edge, neg_edge, evt, sticky, overrun;
   logic       irq;

   edge_detect_mc #(
      .CH(4),
      .SYNC_STAGES(2),
      .DEB_W(8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data_in(data_in),
      .deb_len(deb_len),
      .mode(mode),
      .irq_en(irq_en),
      .clr(clr),
      .data_filt(data_filt),
      .pos_edge(pos_edge),
      .neg_edge(neg_edge),
      .evt(evt),
      .sticky(sticky),
      .overrun(overrun),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         cyc;
      logic [3:0] pos, neg, ev, stk, ovr, filt;
      logic       irq;
      string      name;
   } exp_t;

   exp_t sb[$];

   task automatic push(input int c, input logic [3:0] p, input logic [3:0] n,
                       input logic [3:0] e, input logic [3:0] s, input logic [3:0] o,
                       input logic [3:0] f, input logic i, input string nm);
      exp_t x;
      x.cyc = c; x.pos = p; x.neg = n; x.ev = e; x.stk = s; x.ovr = o;
      x.filt = f; x.irq = i; x.name = nm;
      sb.push_back(x);
   endtask

   // Monitor: every cycle with edge or event activity consumes one record.
   always @(negedge clk) begin
      if ((pos_edge | neg_edge | evt) != 4'h0) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: cyc=%0d pos=%b neg=%b evt=%b, required no activity",
                     cyc, pos_edge, neg_edge, evt);
         end else begin
            exp_t x;
            x = sb.pop_front();
            if (cyc != x.cyc || pos_edge !== x.pos || neg_edge !== x.neg || evt !== x.ev ||
                sticky !== x.stk || overrun !== x.ovr || data_filt !== x.filt || irq !== x.irq) begin
               fails++;
               $display("FAIL %s: got cyc=%0d pos=%b neg=%b evt=%b sticky=%b ovr=%b filt=%b irq=%b; required cyc=%0d pos=%b neg=%b evt=%b sticky=%b ovr=%b filt=%b irq=%b",
                        x.name, cyc, pos_edge, neg_edge, evt, sticky, overrun, data_filt, irq,
                        x.cyc, x.pos, x.neg, x.ev, x.stk, x.ovr, x.filt, x.irq);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   task automatic check_all_zero(input string nm);
      check(nm, {7'd0, data_filt, pos_edge, neg_edge, evt, sticky, overrun, irq}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, m, r;
      logic [3:0] seq [16];
      logic [3:0] prev, p, n;

      seq = '{4'h1, 4'h3, 4'h6, 4'hF, 4'h0, 4'h5, 4'hA, 4'hA,
              4'hC, 4'h1, 4'h0, 4'hF, 4'h8, 4'h0, 4'h0, 4'h0};

      rst_n = 1'b0; data_in = '0; deb_len = 8'd1; mode = 8'h55; irq_en = '0; clr = '0;
      repeat (3) step();
      check_all_zero("reset_state");
      rst_n = 1'b1;
      step(); step();
      check_all_zero("post_release_idle");

      // Basic latency with N=1
      k = cyc; data_in = 4'b0001;
      push(k+3, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, "A_rise");
      wait_until(k+2);
      check("A_filt_pre", 32'(data_filt), 32'h0);
      step();
      check("A_filt_pos", 32'({data_filt, pos_edge}), 32'h11);
      step();
      check("A_pos_gone", 32'(pos_edge), 32'h0);
      check("A_sticky", 32'(sticky), 32'h1);
      clr = 4'hF; step(); clr = '0;
      check("A_clr", 32'(sticky), 32'h0);
      k = cyc; data_in = '0;
      push(k+3, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, "A_fall");
      wait_until(k+4);

      // Debounce N=5: 4-cycle glitch rejected, 5-cycle pulse accepted
      deb_len = 8'd5;
      k = cyc; data_in = 4'b0010;
      wait_until(k+4); data_in = '0;
      wait_until(k+12);
      k = cyc; data_in = 4'b0010;
      push(k+7, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, "B_rise");
      wait_until(k+5); data_in = '0;
      push(k+12, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, "B_fall");
      wait_until(k+14);

      // Falling-only mode on ch0, interrupt enable
      deb_len = 8'd1; clr = 4'hF; mode = 8'h56; irq_en = 4'b0001;
      step(); clr = '0;
      check("C_irq_idle", 32'(irq), 32'h0);
      k = cyc; data_in = 4'b0001;
      push(k+3, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b0, "C_rise");
      wait_until(k+4); data_in = '0; m = k+4;
      push(m+3, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, "C_fall");
      wait_until(m+4);
      check("C_sticky", 32'(sticky), 32'h1);
      check("C_irq_on", 32'(irq), 32'h1);
      irq_en = '0; #1;
      check("C_irq_off", 32'(irq), 32'h0);

      // Overrun on ch2, clear coincident with third event
      clr = 4'hF; step(); clr = '0; mode = 8'h55;
      k = cyc; data_in = 4'b0100;
      push(k+3, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, "D_rise1");
      wait_until(k+4); data_in = '0;
      push(k+7, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, "D_fall1");
      wait_until(k+8);
      k = cyc; data_in = 4'b0100;
      push(k+3, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, "D_rise2");
      wait_until(k+4);
      check("D_sticky2", 32'(sticky), 32'h4);
      check("D_ovr2", 32'(overrun), 32'h4);
      data_in = '0;
      push(k+7, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b0, "D_fall2");
      wait_until(k+8);
      k = cyc; data_in = 4'b0100;
      push(k+3, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1'b0, "D_rise3");
      wait_until(k+3);
      clr = 4'b0100; step(); clr = '0;
      check("D_sticky3", 32'(sticky), 32'h4);
      check("D_ovr3", 32'(overrun), 32'h0);
      data_in = '0;
      push(k+7, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b0, "D_fall3");
      wait_until(k+8);

      // Reset mid-count, release with all inputs high
      deb_len = 8'd5; mode = 8'hFF;
      k = cyc; data_in = 4'hF;
      wait_until(k+4);
      rst_n = 1'b0; #1;
      check_all_zero("E_rst_async");
      step(); step(); step();
      rst_n = 1'b1; r = cyc;
      push(r+7, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0, "E_release");
      wait_until(r+8);
      check("E_sticky", 32'(sticky), 32'hF);

      k = cyc; data_in = '0;
      push(k+7, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, "F_fall");
      wait_until(k+8);
      check("F_ovr", 32'(overrun), 32'hF);
      clr = 4'hF; mode = '0; step(); clr = '0;
      check("F_clr", 32'({sticky, overrun}), 32'h0);

      // With N=1 the filtered level is the input delayed by three cycles,
      // for deb_len=0 and deb_len=1 alike.
      for (int pass = 0; pass < 2; pass++) begin
         deb_len = 8'(pass);
         prev = 4'h0;
         for (int j = 0; j < 16; j++) begin
            k = cyc; data_in = seq[j];
            p = seq[j] & ~prev;
            n = ~seq[j] & prev;
            if ((p | n) != 4'h0)
               push(k+3, p, n, 4'h0, 4'h0, 4'h0, seq[j], 1'b0,
                    $sformatf("T_dl%0d_step%0d", pass, j));
            prev = seq[j];
            step();
         end
         repeat (6) step();
      end

      for (int w = 0; w < 20 && sb.size() != 0; w++) step();
      while (sb.size() != 0) begin
         exp_t x;
         x = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: no output seen, required activity at cyc=%0d", x.name, x.cyc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
